// File: rtl/player_shot_ctrl.sv
// Player cannon movement and single-bullet launcher driven by keyboard action codes.
// One bullet at a time; it rises each frame until it reaches the top or is hit.
module player_shot_ctrl #(
  parameter int SHIP_W      = 32,
  parameter int X_MAX       = 608,
  parameter int X_START     = 304,
  parameter int STEP        = 4,
  parameter int SHIP_Y      = 440,
  parameter int BULLET_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] action,
  input  logic       frame_tick,
  input  logic       bullet_hit,
  output logic [9:0] player_x,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       shot_fired
);

  localparam logic [3:0] ACT_FIRE  = 4'b0010;
  localparam logic [3:0] ACT_LEFT  = 4'b0100;
  localparam logic [3:0] ACT_RIGHT = 4'b1000;

  localparam logic [9:0] STEP_W        = 10'(STEP);
  localparam logic [9:0] X_MAX_W       = 10'(X_MAX);
  localparam logic [9:0] X_START_W     = 10'(X_START);
  localparam logic [9:0] HALF_SHIP_W   = 10'(SHIP_W / 2);
  localparam logic [9:0] SHIP_Y_W      = 10'(SHIP_Y);
  localparam logic [9:0] BULLET_STEP_W = 10'(BULLET_STEP);

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [9:0] player_x_reg, player_x_next;
  logic [9:0] bullet_x_reg, bullet_x_next;
  logic [9:0] bullet_y_reg, bullet_y_next;
  logic       shot_fired_reg, shot_fired_next;
  logic       fire_prev_reg;
  logic       fire_now;
  logic       fire_edge;

  assign fire_now  = (action == ACT_FIRE);
  assign fire_edge = fire_now & ~fire_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      player_x_reg   <= X_START_W;
      bullet_x_reg   <= '0;
      bullet_y_reg   <= '0;
      shot_fired_reg <= 1'b0;
      fire_prev_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      player_x_reg   <= player_x_next;
      bullet_x_reg   <= bullet_x_next;
      bullet_y_reg   <= bullet_y_next;
      shot_fired_reg <= shot_fired_next;
      fire_prev_reg  <= fire_now;
    end
  end

  // Clamp tests come before the arithmetic so the 10-bit result never wraps.
  always_comb begin
    player_x_next = player_x_reg;
    if (frame_tick) begin
      if (action == ACT_LEFT) begin
        player_x_next = (player_x_reg < STEP_W) ? '0 : player_x_reg - STEP_W;
      end else if (action == ACT_RIGHT) begin
        player_x_next = (player_x_reg > X_MAX_W - STEP_W) ? X_MAX_W : player_x_reg + STEP_W;
      end
    end
  end

  // Hit outranks the frame step; fire edges while a bullet is airborne are dropped.
  always_comb begin
    state_next      = state_reg;
    bullet_x_next   = bullet_x_reg;
    bullet_y_next   = bullet_y_reg;
    shot_fired_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fire_edge) begin
          state_next      = FLYING;
          bullet_x_next   = player_x_reg + HALF_SHIP_W;
          bullet_y_next   = SHIP_Y_W;
          shot_fired_next = 1'b1;
        end
      end
      FLYING: begin
        if (bullet_hit) begin
          state_next = IDLE;
        end else if (frame_tick) begin
          if (bullet_y_reg < BULLET_STEP_W) begin
            state_next = IDLE;
          end else begin
            bullet_y_next = bullet_y_reg - BULLET_STEP_W;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign player_x      = player_x_reg;
  assign bullet_active = (state_reg == FLYING);
  assign bullet_x      = bullet_x_reg;
  assign bullet_y      = bullet_y_reg;
  assign shot_fired    = shot_fired_reg;

endmodule
